// File: rtl/cska_pkg.sv
// Shared constants for the 32-bit carry-skip adder.
//   ADD_W    : adder width in bits
//   BLOCK_W  : bits per ripple/skip block
//   N_BLOCKS : number of skip blocks across the adder
package cska_pkg;
    localparam int ADD_W    = 32;
    localparam int BLOCK_W  = 4;
    localparam int N_BLOCKS = ADD_W / BLOCK_W;
endpackage

// File: rtl/cska_block.sv
// One carry-skip block: a BLOCK_W-bit ripple adder whose carry-out
// bypasses the ripple chain whenever every bit in the block propagates.
// Ports:
//   a, b   : block operand slices
//   cin    : carry into the block's lowest bit
//   sum    : block sum bits, from the ripple carries seeded by cin
//   cout   : skip-muxed carry out of the block
//   blk_p  : block propagate (AND of all bit propagates)
module cska_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] sum,
    output logic               cout,
    output logic               blk_p
);
    logic [BLOCK_W-1:0] p;
    logic [BLOCK_W-1:0] g;
    logic [BLOCK_W:0]   c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < BLOCK_W; gi++) begin : g_bit
            assign p[gi]   = a[gi] ^ b[gi];
            assign g[gi]   = a[gi] & b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
            assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
        end
    endgenerate

    assign blk_p = &p;
    // When the whole block propagates, the ripple carry-out equals cin
    // anyway; taking cin directly removes the ripple from the inter-block
    // carry path.
    assign cout  = blk_p ? cin : c[BLOCK_W];
endmodule

// File: rtl/cska_32.sv
// 32-bit carry-skip adder with a registered result stage (1-cycle latency).
// Ports:
//   clk       : clock, all state updates on rising edge
//   rst       : synchronous active-high reset, clears the outputs
//   Cin       : carry into bit 0
//   operA     : addend A, unsigned
//   operB     : addend B, unsigned
//   resultOUT : registered sum bits [31:0]
//   Cout      : registered carry out of bit 31
module cska_32 #(
    parameter int BLOCK_W = cska_pkg::BLOCK_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Cin,
    input  logic [31:0] operA,
    input  logic [31:0] operB,
    output logic [31:0] resultOUT,
    output logic        Cout
);
    import cska_pkg::ADD_W;

    localparam int N_BLK = ADD_W / BLOCK_W;

    logic [N_BLK:0]    blk_c;
    logic [N_BLK-1:0]  blk_p;
    logic [ADD_W-1:0]  sum_next;
    logic [ADD_W-1:0]  sum_reg;
    logic              cout_reg;

    assign blk_c[0] = Cin;

    generate
        for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
            cska_block #(
                .BLOCK_W (BLOCK_W)
            ) u_block (
                .a     (operA[gi*BLOCK_W +: BLOCK_W]),
                .b     (operB[gi*BLOCK_W +: BLOCK_W]),
                .cin   (blk_c[gi]),
                .sum   (sum_next[gi*BLOCK_W +: BLOCK_W]),
                .cout  (blk_c[gi+1]),
                .blk_p (blk_p[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            sum_reg  <= sum_next;
            cout_reg <= blk_c[N_BLK];
        end
    end

    assign resultOUT = sum_reg;
    assign Cout      = cout_reg;

    // Block propagates are exposed by each block for observability; they
    // do not feed the registered outputs beyond the skip muxes.
    logic unused_blk_p;
    assign unused_blk_p = ^blk_p;
endmodule

// File: tb/tb_cska_32.sv
module tb_cska_32;
    logic        clk;
    logic        rst;
    logic        Cin;
    logic [31:0] operA;
    logic [31:0] operB;
    logic [31:0] resultOUT;
    logic        Cout;

    int n_vec  = 0;
    int n_miss = 0;

    cska_32 dut (
        .clk       (clk),
        .rst       (rst),
        .Cin       (Cin),
        .operA     (operA),
        .operB     (operB),
        .resultOUT (resultOUT),
        .Cout      (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Drive one set of inputs, let one rising edge pass, then compare the
    // registered outputs against a hand-computed value.
    task automatic apply(input string tag, input logic r, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic [32:0] exp);
        rst = r; operA = a; operB = b; Cin = c;
        @(posedge clk);
        #1;
        check_vec(tag, {Cout, resultOUT}, exp);
    endtask

    initial begin
        logic [32:0] ref_sum;
        logic [31:0] ra, rb;
        logic        rc;

        rst = 1'b1; operA = 32'hDEADBEEF; operB = 32'hFFFFFFFF; Cin = 1'b1;

        apply("reset_1",  1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 33'h0);
        apply("reset_2",  1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 33'h0);
        apply("one_one",  1'b0, 32'h00000001, 32'h00000001, 1'b0, {1'b0, 32'h00000002});
        apply("zero",     1'b0, 32'h00000000, 32'h00000000, 1'b0, {1'b0, 32'h00000000});
        apply("max_wrap", 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, {1'b1, 32'h00000000});
        apply("mixed",    1'b0, 32'h12345678, 32'h87654321, 1'b0, {1'b0, 32'h99999999});
        apply("skip_all", 1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b1, {1'b1, 32'h00000000});
        apply("skip_nc",  1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b0, {1'b0, 32'hFFFFFFFF});
        apply("max_max",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF});
        apply("blk_skip", 1'b0, 32'h0000000F, 32'h00000000, 1'b1, {1'b0, 32'h00000010});
        apply("gen_hi",   1'b0, 32'h80000000, 32'h80000000, 1'b0, {1'b1, 32'h00000000});
        // Reset mid-stream dominates inputs, next add follows on the next edge.
        apply("mid_rst",  1'b1, 32'h12345678, 32'h11111111, 1'b1, 33'h0);
        apply("post_rst", 1'b0, 32'h00000003, 32'h00000004, 1'b1, {1'b0, 32'h00000008});

        // Random stream with one mid-stream reset cycle.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i == 5000) begin
                apply("rnd_rst", 1'b1, ra, rb, rc, 33'h0);
            end else begin
                ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
                rst = 1'b0; operA = ra; operB = rb; Cin = rc;
                @(posedge clk);
                #1;
                n_vec++;
                if ({Cout, resultOUT} !== ref_sum) begin
                    n_miss++;
                    $display("FAIL rnd[%0d]: %h+%h+%b got %h, expected %h",
                             i, ra, rb, rc, {Cout, resultOUT}, ref_sum);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
